// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants, FSM encoding and BCD helper for the 7-segment display sequencer.
package seg_display_ctrl_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         SEG_DP_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2
    } state_e;

    // Double-dabble correction: a nibble that will reach >= 10 after the shift gets +3 first.
    function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Valid/ready input channel carrying the binary value and its decimal-point mask.
interface seg_display_ctrl_if #(
    parameter int NDIG = 4,
    parameter int W    = 14
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [NDIG-1:0] in_dp;

    modport master (output in_valid, output in_data, output in_dp, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_dp, output in_ready);
endinterface

// File: rtl/seg_display_ctrl_bcd7seq.sv
// BCD to active-low 7-segment decoder; byte layout {a,b,c,d,e,f,g,dp}, dp returned unlit.
module bcd7seq
    import seg_display_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dec_i,   // 1 = show A-F for codes 10..15, 0 = blank them
    input  logic       off_i,
    output logic [7:0] seg_o
);

    logic [6:0] abcdefg;

    always_comb begin
        abcdefg = 7'h7F;
        unique case (bcd_i)
            4'h0: abcdefg = 7'b000_0001;
            4'h1: abcdefg = 7'b100_1111;
            4'h2: abcdefg = 7'b001_0010;
            4'h3: abcdefg = 7'b000_0110;
            4'h4: abcdefg = 7'b100_1100;
            4'h5: abcdefg = 7'b010_0100;
            4'h6: abcdefg = 7'b010_0000;
            4'h7: abcdefg = 7'b000_1111;
            4'h8: abcdefg = 7'b000_0000;
            4'h9: abcdefg = 7'b000_0100;
            4'hA: abcdefg = dec_i ? 7'b000_1000 : 7'h7F;
            4'hB: abcdefg = dec_i ? 7'b110_0000 : 7'h7F;
            4'hC: abcdefg = dec_i ? 7'b011_0001 : 7'h7F;
            4'hD: abcdefg = dec_i ? 7'b100_0010 : 7'h7F;
            4'hE: abcdefg = dec_i ? 7'b011_0000 : 7'h7F;
            4'hF: abcdefg = dec_i ? 7'b011_1000 : 7'h7F;
            default: abcdefg = 7'h7F;
        endcase
        seg_o = off_i ? SEG_BLANK : {abcdefg, 1'b1};
    end

endmodule

// File: rtl/seg_display_ctrl_dd_step.sv
// One double-dabble iteration over NDIG BCD nibbles: add-3 correction, then shift in one binary bit.
module bcd_dd_step
    import seg_display_ctrl_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic [4*NDIG-1:0] bcd_i,
    input  logic              bit_i,
    output logic [4*NDIG-1:0] bcd_o
);

    logic [4*NDIG-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < NDIG; i++) begin
            adj[4*i +: 4] = bcd_add3(bcd_i[4*i +: 4]);
        end
        // The top bit falls off only for values that are flagged as overflow anyway.
        bcd_o = (adj << 1) | {{(4*NDIG-1){1'b0}}, bit_i};
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// NDIG-digit 7-segment sequencer: accepts a binary value, converts it to BCD one bit per clock
// and drives per-digit decoders with leading-zero blanking, decimal points, overflow and blink.
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int W         = 14,
    parameter int BLINK_DIV = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_display_ctrl_if.slave   bus,
    input  logic                blank_lz,
    input  logic                blink_en,
    output logic                busy,
    output logic                ovf,
    output logic [8*NDIG-1:0]   seg
);

    localparam int           CW        = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
    localparam logic [W-1:0]  MAX_VAL   = W'(10**NDIG - 1);

    state_e                 state_q;
    logic [W-1:0]           shift_q;
    logic [4*NDIG-1:0]      acc_q;
    logic [4*NDIG-1:0]      acc_d;
    logic [CW-1:0]          step_q;
    logic [NDIG-1:0]        dp_lat_q;
    logic                   ovf_next_q;
    logic [4*NDIG-1:0]      digits_q;
    logic [NDIG-1:0]        dp_q;
    logic                   ovf_q;
    logic                   disp_vld_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic [BLINK_DIV-1:0]   blink_q;
    logic                   accept;

    assign accept       = bus.in_valid && in_ready_q;
    assign bus.in_ready = in_ready_q;
    assign busy         = busy_q;
    assign ovf          = ovf_q;

    bcd_dd_step #(.NDIG(NDIG)) u_step (
        .bcd_i (acc_q),
        .bit_i (shift_q[W-1]),
        .bcd_o (acc_d)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the digit/dp registers are reset too, so the display starts blank rather than undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            dp_lat_q   <= '0;
            ovf_next_q <= 1'b0;
            digits_q   <= '0;
            dp_q       <= '0;
            ovf_q      <= 1'b0;
            disp_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            blink_q    <= '0;
        end else begin
            blink_q <= blink_q + 1'b1;
            unique case (state_q)
                ST_IDLE, ST_SHOW: begin
                    if (accept) begin
                        shift_q    <= bus.in_data;
                        acc_q      <= '0;
                        step_q     <= '0;
                        dp_lat_q   <= bus.in_dp;
                        ovf_next_q <= (bus.in_data > MAX_VAL);
                        state_q    <= ST_CONV;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CONV: begin
                    shift_q <= shift_q << 1;
                    acc_q   <= acc_d;
                    step_q  <= step_q + 1'b1;
                    // The last step's result goes straight to the display registers.
                    if (step_q == LAST_STEP) begin
                        digits_q   <= acc_d;
                        dp_q       <= dp_lat_q;
                        ovf_q      <= ovf_next_q;
                        disp_vld_q <= 1'b1;
                        state_q    <= ST_SHOW;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    logic [NDIG-1:0] off;

    // NOTE: blocking assignments here build a combinational ripple from the top digit down.
    always_comb begin
        logic lz_run;
        lz_run = 1'b1;
        off    = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lz_run = lz_run & (digits_q[4*i +: 4] == 4'd0);
            off[i] = !disp_vld_q | ovf_q | (blink_en & blink_q[BLINK_DIV-1])
                   | (blank_lz & (i != 0) & lz_run);
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        logic [7:0] dec_seg;
        logic [7:0] seg_byte;

        bcd7seq u_dec (
            .bcd_i (digits_q[4*g +: 4]),
            .dec_i (1'b0),
            .off_i (off[g]),
            .seg_o (dec_seg)
        );

        always_comb begin
            seg_byte = dec_seg;
            if (dp_q[g] && !off[g]) begin
                seg_byte[SEG_DP_BIT] = 1'b0;
            end
        end

        assign seg[8*g +: 8] = seg_byte;
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: expected displays queued on send, compared on commit.
module tb_seg_display_ctrl;

    localparam int NDIG      = 4;
    localparam int W         = 14;
    localparam int BLINK_DIV = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        blank_lz;
    logic        blink_en;
    logic        busy;
    logic        ovf;
    logic [31:0] seg;

    always #5 clk = ~clk;

    seg_display_ctrl_if #(.NDIG(NDIG), .W(W)) bus ();

    seg_display_ctrl #(.NDIG(NDIG), .W(W), .BLINK_DIV(BLINK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .busy     (busy),
        .ovf      (ovf),
        .seg      (seg)
    );

    typedef struct {
        logic [31:0] seg;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    bit          disp_valid = 1'b0;
    int          disp_val   = 0;
    logic [3:0]  disp_dp    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] digit_code(input int d);
        case (d)
            0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
            4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
            8: return 8'h01;  9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] model(input int value, input logic [3:0] dp, input logic lz);
        logic [31:0] r;
        logic        zero_run;
        logic        off;
        int          d;
        int          p;
        r = 32'hFFFF_FFFF;
        if (value > 9999) return r;
        zero_run = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            d = (value / p) % 10;
            zero_run = zero_run && (d == 0);
            off = lz && (i != 0) && zero_run;
            r[8*i +: 8] = off ? 8'hFF : digit_code(d);
            if (dp[i] && !off) r[8*i] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] shown_now();
        return disp_valid ? model(disp_val, disp_dp, blank_lz) : 32'hFFFF_FFFF;
    endfunction

    task automatic push_exp(input int value, input logic [3:0] dp);
        exp_t e;
        e.seg = model(value, dp, blank_lz);
        e.ovf = (value > 9999);
        sb.push_back(e);
    endtask

    task automatic wait_busy_low(input string tag, output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 100) check({tag, "_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic compare_commit(input string tag, input int value, input logic [3:0] dp);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_seg"}, seg, e.seg);
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
        check({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd1);
        disp_valid = 1'b1;
        disp_val   = value;
        disp_dp    = dp;
    endtask

    task automatic txn(input string tag, input int value, input logic [3:0] dp);
        int          cyc;
        int          k;
        logic [31:0] hold;
        hold = shown_now();
        push_exp(value, dp);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(value);
        bus.in_dp    = dp;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_hold"}, seg, hold);
        wait_busy_low(tag, cyc);
        check({tag, "_latency"}, cyc, W);
        compare_commit(tag, value, dp);
    endtask

    initial begin
        int          cyc;
        int          k;
        logic [31:0] s[16];
        logic [31:0] val;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_dp    = '0;
        blank_lz     = 1'b0;
        blink_en     = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_seg", seg, 32'hFFFF_FFFF);
        check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_seg", seg, 32'hFFFF_FFFF);
        check("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);

        txn("v1234", 1234, 4'b0000);
        blank_lz = 1'b1;
        txn("v7_lz", 7, 4'b0000);
        blank_lz = 1'b0;
        txn("v7", 7, 4'b0000);
        blank_lz = 1'b1;
        txn("v0_lz", 0, 4'b0000);
        blank_lz = 1'b0;
        txn("v12000", 12000, 4'b0000);
        txn("v5", 5, 4'b0000);

        // Source holds in_valid through the conversion and switches data to 42.
        push_exp(1234, 4'b0000);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(1234);
        bus.in_dp    = '0;
        @(posedge clk);
        #1 bus.in_data = W'(42);
        @(negedge clk);
        wait_busy_low("held_1234", cyc);
        check("held_1234_latency", cyc, W);
        compare_commit("held_1234", 1234, 4'b0000);
        push_exp(42, 4'b0000);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("held_42_busy", {31'b0, busy}, 32'd1);
        check("held_42_hold", seg, shown_now());
        wait_busy_low("held_42", cyc);
        compare_commit("held_42", 42, 4'b0000);

        // Reset in the middle of a conversion drops it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(9876);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_seg", seg, 32'hFFFF_FFFF);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_ready", {31'b0, bus.in_ready}, 32'd1);
        disp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("midrst_after_seg", seg, 32'hFFFF_FFFF);
        check("midrst_after_busy", {31'b0, busy}, 32'd0);

        txn("dp_1234", 1234, 4'b0100);
        check("dp_digit2", {24'b0, seg[23:16]}, 32'h24);

        val = model(1234, 4'b0100, 1'b0);
        blink_en = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            s[j] = seg;
        end
        for (int j = 4; j < 16; j++) begin
            check($sformatf("blink_%0d", j), s[j], (s[j-4] == 32'hFFFF_FFFF) ? val : 32'hFFFF_FFFF);
        end
        blink_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
